// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multicycle control sequencer for the 64-bit datapath.
// Walks each instruction through fetch/decode/execute/memory/writeback,
// drives the alu selects and every write enable, counts retired
// instructions and flags undefined opcodes.
module mc_control_fsm #(
  parameter int COUNT_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         opcode,
  input  logic [2:0]         funct,
  input  logic               zero,
  input  logic               mem_ready,
  output logic [2:0]         ALU_Op,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         pc_src,
  output logic               pc_write,
  output logic               ir_write,
  output logic               reg_write,
  output logic               mem_read,
  output logic               mem_write,
  output logic               iord,
  output logic               mem_to_reg,
  output logic               reg_dst,
  output logic               retire,
  output logic [COUNT_W-1:0] instr_count,
  output logic               illegal
);

  localparam logic [3:0] OP_R    = 4'd0;
  localparam logic [3:0] OP_ADDI = 4'd1;
  localparam logic [3:0] OP_LD   = 4'd2;
  localparam logic [3:0] OP_ST   = 4'd3;
  localparam logic [3:0] OP_BEQ  = 4'd4;
  localparam logic [3:0] OP_JMP  = 4'd5;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_ALUWB, S_MEMADR,
    S_MEMRD, S_MEMWB, S_MEMWR, S_BRANCH, S_JUMP
  } state_t;

  state_t state, state_nxt;
  logic   ill_set;

  // State register; reset parks the machine in FETCH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= state_nxt;
  end

  // Next-state and control decode; outputs forced low while reset is held
  // so an aborted instruction cannot write anything.
  always_comb begin
    state_nxt  = state;
    ALU_Op     = 3'd0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'd0;
    pc_src     = 2'd0;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    mem_to_reg = 1'b0;
    reg_dst    = 1'b0;
    retire     = 1'b0;
    ill_set    = 1'b0;
    case (state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'd1;
        if (mem_ready) begin
          ir_write  = 1'b1;
          pc_write  = 1'b1;
          state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_b = 2'd3;
        case (opcode)
          OP_R:         state_nxt = S_EXEC_R;
          OP_ADDI:      state_nxt = S_EXEC_I;
          OP_LD, OP_ST: state_nxt = S_MEMADR;
          OP_BEQ:       state_nxt = S_BRANCH;
          OP_JMP:       state_nxt = S_JUMP;
          default: begin
            state_nxt = S_FETCH;
            ill_set   = 1'b1;
          end
        endcase
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        ALU_Op    = funct;
        state_nxt = S_ALUWB;
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        state_nxt = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = (opcode == OP_R);
        retire    = 1'b1;
        state_nxt = S_FETCH;
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        state_nxt = (opcode == OP_LD) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (mem_ready) state_nxt = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
        state_nxt  = S_FETCH;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        if (mem_ready) begin
          retire    = 1'b1;
          state_nxt = S_FETCH;
        end
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        ALU_Op    = 3'd1;
        pc_src    = 2'd1;
        pc_write  = zero;
        retire    = 1'b1;
        state_nxt = S_FETCH;
      end
      S_JUMP: begin
        pc_src    = 2'd2;
        pc_write  = 1'b1;
        retire    = 1'b1;
        state_nxt = S_FETCH;
      end
      default: state_nxt = S_FETCH;
    endcase
    if (!rst_n) begin
      ALU_Op     = 3'd0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'd0;
      pc_src     = 2'd0;
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      iord       = 1'b0;
      mem_to_reg = 1'b0;
      reg_dst    = 1'b0;
      retire     = 1'b0;
      ill_set    = 1'b0;
    end
  end

  // Retired-instruction counter (free-running wrap) and sticky illegal flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_count <= '0;
      illegal     <= 1'b0;
    end else begin
      if (retire)  instr_count <= instr_count + COUNT_W'(1);
      if (ill_set) illegal     <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm; per-cycle control vectors are hand
// derived from the state table, counter built with COUNT_W=4 to hit wrap.
module tb_mc_control_fsm;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] opcode = '0;
  logic [2:0] funct = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic [2:0] ALU_Op;
  logic       alu_src_a;
  logic [1:0] alu_src_b, pc_src;
  logic       pc_write, ir_write, reg_write, mem_read, mem_write;
  logic       iord, mem_to_reg, reg_dst, retire, illegal;
  logic [3:0] instr_count;
  logic [17:0] ctl;
  int checks = 0;
  int errors = 0;

  mc_control_fsm #(.COUNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .ALU_Op(ALU_Op), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .pc_src(pc_src), .pc_write(pc_write),
    .ir_write(ir_write), .reg_write(reg_write), .mem_read(mem_read),
    .mem_write(mem_write), .iord(iord), .mem_to_reg(mem_to_reg),
    .reg_dst(reg_dst), .retire(retire), .instr_count(instr_count),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  assign ctl = {ALU_Op, alu_src_a, alu_src_b, pc_src, pc_write, ir_write, reg_write,
                mem_read, mem_write, iord, mem_to_reg, reg_dst, retire};

  // Expected control vector builder, same field order as ctl.
  function automatic logic [17:0] ev(input logic [2:0] alu, input logic sa,
      input logic [1:0] sb, input logic [1:0] ps, input logic pw, input logic irw,
      input logic rw, input logic mr, input logic mw, input logic io,
      input logic m2r, input logic rd, input logic ret);
    return {alu, sa, sb, ps, pw, irw, rw, mr, mw, io, m2r, rd, ret};
  endfunction

  logic [17:0] F1, F0, DEC, MADR, JMPV;
  initial begin
    F1   = ev(0,0,1,0,1,1,0,1,0,0,0,0,0);
    F0   = ev(0,0,1,0,0,0,0,1,0,0,0,0,0);
    DEC  = ev(0,0,3,0,0,0,0,0,0,0,0,0,0);
    MADR = ev(0,1,2,0,0,0,0,0,0,0,0,0,0);
    JMPV = ev(0,0,0,2,1,0,0,0,0,0,0,0,1);
  end

  task automatic test_reset();
    mem_ready = 1'b1;
    #2;
    checks++;
    if (ctl !== 18'd0) begin errors++; $display("FAIL reset_ctl got %h want %h", ctl, 18'd0); end
    checks++;
    if (instr_count !== 4'd0 || illegal !== 1'b0) begin
      errors++; $display("FAIL reset_regs got cnt=%0d ill=%b want cnt=0 ill=0", instr_count, illegal);
    end
    @(posedge clk); #2 rst_n = 1'b1;
  endtask

  task automatic test_rtype();
    logic [17:0] e [4];
    e = '{F1, DEC, ev(1,1,0,0,0,0,0,0,0,0,0,0,0), ev(0,0,0,0,0,0,1,0,0,0,0,1,1)};
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); opcode = 4'd0; funct = 3'd1; mem_ready = 1'b1; #1;
      checks++;
      if (ctl !== e[c]) begin errors++; $display("FAIL rtype_c%0d got %h want %h", c, ctl, e[c]); end
    end
    @(posedge clk); #1;
    checks++;
    if (instr_count !== 4'd1) begin errors++; $display("FAIL rtype_cnt got %0d want 1", instr_count); end
  endtask

  task automatic test_addi();
    logic [17:0] e [4];
    e = '{F1, DEC, MADR, ev(0,0,0,0,0,0,1,0,0,0,0,0,1)};
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); opcode = 4'd1; funct = 3'd6; #1;
      checks++;
      if (ctl !== e[c]) begin errors++; $display("FAIL addi_c%0d got %h want %h", c, ctl, e[c]); end
    end
    @(posedge clk); #1;
    checks++;
    if (instr_count !== 4'd2) begin errors++; $display("FAIL addi_cnt got %0d want 2", instr_count); end
  endtask

  // Store with one FETCH stall cycle.
  task automatic test_store();
    logic [17:0] e [5];
    logic mr [5];
    e  = '{F0, F1, DEC, MADR, ev(0,0,0,0,0,0,0,0,1,1,0,0,1)};
    mr = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); opcode = 4'd3; mem_ready = mr[c]; #1;
      checks++;
      if (ctl !== e[c]) begin errors++; $display("FAIL store_c%0d got %h want %h", c, ctl, e[c]); end
    end
    @(posedge clk); #1;
    checks++;
    if (instr_count !== 4'd3) begin errors++; $display("FAIL store_cnt got %0d want 3", instr_count); end
  endtask

  // Load with three MEMRD stall cycles: 8 cycles total.
  task automatic test_load_stall();
    logic [17:0] e [8];
    logic mr [8];
    logic [17:0] rd;
    rd = ev(0,0,0,0,0,0,0,1,0,1,0,0,0);
    e  = '{F1, DEC, MADR, rd, rd, rd, rd, ev(0,0,0,0,0,0,1,0,0,0,1,0,1)};
    mr = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int c = 0; c < 8; c++) begin
      @(negedge clk); opcode = 4'd2; mem_ready = mr[c]; #1;
      checks++;
      if (ctl !== e[c]) begin errors++; $display("FAIL load_c%0d got %h want %h", c, ctl, e[c]); end
    end
    mem_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (instr_count !== 4'd4) begin errors++; $display("FAIL load_cnt got %0d want 4", instr_count); end
  endtask

  // BEQ taken then not taken, back to back.
  task automatic test_branch();
    logic [17:0] e [6];
    logic z [6];
    e = '{F1, DEC, ev(1,1,0,1,1,0,0,0,0,0,0,0,1), F1, DEC, ev(1,1,0,1,0,0,0,0,0,0,0,0,1)};
    z = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); opcode = 4'd4; zero = z[c]; #1;
      checks++;
      if (ctl !== e[c]) begin errors++; $display("FAIL beq_c%0d got %h want %h", c, ctl, e[c]); end
    end
    @(posedge clk); #1;
    checks++;
    if (instr_count !== 4'd6) begin errors++; $display("FAIL beq_cnt got %0d want 6", instr_count); end
  endtask

  task automatic test_illegal();
    logic [17:0] e [3];
    e = '{F1, DEC, JMPV};
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); opcode = 4'd9; #1;
      checks++;
      if (ctl !== e[c] || illegal !== 1'b0) begin
        errors++; $display("FAIL ill_c%0d got %h ill=%b want %h ill=0", c, ctl, illegal, e[c]);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (illegal !== 1'b1 || instr_count !== 4'd6) begin
      errors++; $display("FAIL ill_flag got ill=%b cnt=%0d want ill=1 cnt=6", illegal, instr_count);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); opcode = 4'd5; #1;
      checks++;
      if (ctl !== e[c]) begin errors++; $display("FAIL ill_jmp_c%0d got %h want %h", c, ctl, e[c]); end
    end
    @(posedge clk); #1;
    checks++;
    if (illegal !== 1'b1 || instr_count !== 4'd7) begin
      errors++; $display("FAIL ill_after got ill=%b cnt=%0d want ill=1 cnt=7", illegal, instr_count);
    end
  endtask

  task automatic test_counter_wrap();
    logic [3:0] want;
    rst_n = 1'b0; #1;
    checks++;
    if (instr_count !== 4'd0) begin errors++; $display("FAIL wrap_rst got %0d want 0", instr_count); end
    @(posedge clk); #2 rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      for (int c = 0; c < 3; c++) begin
        @(negedge clk); opcode = 4'd5;
      end
      #1;
      checks++;
      if (ctl !== JMPV) begin errors++; $display("FAIL wrap_jmp%0d got %h want %h", i, ctl, JMPV); end
      @(posedge clk); #1;
      want = (i == 15) ? 4'd0 : 4'(i + 1);
      checks++;
      if (instr_count !== want) begin errors++; $display("FAIL wrap_cnt%0d got %0d want %0d", i, instr_count, want); end
    end
  endtask

  task automatic test_reset_mid_op();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); opcode = 4'd5; mem_ready = 1'b1;
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); opcode = 4'd3; mem_ready = 1'b1;
    end
    @(negedge clk); mem_ready = 1'b0; #1;
    checks++;
    if (ctl !== ev(0,0,0,0,0,0,0,0,1,1,0,0,0) || instr_count !== 4'd1) begin
      errors++; $display("FAIL midrst_pre got %h cnt=%0d want mem_write stall cnt=1", ctl, instr_count);
    end
    #2 rst_n = 1'b0; #1;
    checks++;
    if (mem_write !== 1'b0 || ctl !== 18'd0 || instr_count !== 4'd0) begin
      errors++; $display("FAIL midrst_async got ctl=%h cnt=%0d want 0 0", ctl, instr_count);
    end
    @(posedge clk); #2 rst_n = 1'b1;
    @(negedge clk); mem_ready = 1'b1; #1;
    checks++;
    if (ctl !== F1 || instr_count !== 4'd0) begin
      errors++; $display("FAIL midrst_fetch got %h cnt=%0d want %h 0", ctl, instr_count, F1);
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_addi();
    test_store();
    test_load_stall();
    test_branch();
    test_illegal();
    test_counter_wrap();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
